// File: rtl/output_port_arbiter_pkg.sv
// Package noc_arb_pkg for the output_port_arbiter codebase slice.
//   arb_state_e   : arbiter FSM states (IDLE, GRANT, RELEASE)
//   onehot_to_idx : binary index of the lowest set bit of a one-hot vector
//                   (vectors up to 32 bits wide)
package noc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    localparam int MAX_ONEHOT_W = 32;

    function automatic logic [4:0] onehot_to_idx(input logic [MAX_ONEHOT_W-1:0] oh);
        logic [4:0] idx;
        idx = '0;
        // Scan downward so the lowest set bit wins if the input is not one-hot.
        for (int i = MAX_ONEHOT_W - 1; i >= 0; i--) begin
            if (oh[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/output_port_arbiter_if.sv
// output_port_arbiter_if: request/grant bundle between the input ports and
// one output-port arbiter.
//   req_i           : level request per input port (head flit waiting)
//   tail_i          : one-cycle tail-transfer pulse per input port
//   busy_dw_i       : downstream not ready; blocks new grants only
//   grant_o         : one-hot registered grant
//   grant_id_o      : binary index of current or last grant
//   packet_enable_o : high while a packet holds the port
//   timeout_o       : one-cycle pulse on forced release
// Modports: slave = arbiter side, master = requester/testbench side.
interface output_port_arbiter_if #(
    parameter int INPORTS = 4
) ();
    import noc_arb_pkg::*;

    logic [INPORTS-1:0]         req_i;
    logic [INPORTS-1:0]         tail_i;
    logic                       busy_dw_i;
    logic [INPORTS-1:0]         grant_o;
    logic [$clog2(INPORTS)-1:0] grant_id_o;
    logic                       packet_enable_o;
    logic                       timeout_o;

    modport slave (
        input  req_i, tail_i, busy_dw_i,
        output grant_o, grant_id_o, packet_enable_o, timeout_o
    );

    modport master (
        output req_i, tail_i, busy_dw_i,
        input  grant_o, grant_id_o, packet_enable_o, timeout_o
    );
endinterface

// File: rtl/output_port_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector.
//   req   : request vector (W bits)
//   ptr   : index of the last winner; scanning starts at ptr+1 with wrap
//   gnt   : one-hot winner (zero when no request)
//   idx   : binary index of the winner
//   any   : at least one request present
module rr_picker
    import noc_arb_pkg::*;
#(
    parameter int W  = 4,
    parameter int IW = $clog2(W)
) (
    input  logic [W-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [W-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [IW-1:0] pos;
    logic          found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        pos   = '0;
        // Offsets 1..W visit every port once, ending on ptr itself, so the
        // last winner only wins again when it is the sole requester.
        for (int k = 1; k <= W; k++) begin
            pos = IW'((int'(ptr) + k) % W);
            if (!found && req[pos]) begin
                gnt[pos] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign idx = IW'(onehot_to_idx(MAX_ONEHOT_W'(gnt)));
    assign any = |req;

endmodule

// File: rtl/output_port_arbiter.sv
// output_port_arbiter: shares one router output port among INPORTS input
// ports at packet granularity. A head-flit request wins round-robin, holds
// the port until its own tail pulse, then one idle RELEASE cycle precedes
// re-arbitration.
// Ports:
//   clk     : clock, all state on rising edge
//   reset_n : asynchronous active-low reset
//   bus     : output_port_arbiter_if.slave (req/tail/busy in, grant out)
// Parameters: INPORTS, LOCATION (own input, always masked), TIMEOUT_CYCLES.
// Optional feature: define OUTPORT_ARB_TIMEOUT_EN to force release of a
// grant held TIMEOUT_CYCLES cycles without a tail; otherwise timeout_o = 0.
module output_port_arbiter
    import noc_arb_pkg::*;
#(
    parameter int INPORTS        = 4,
    parameter int LOCATION       = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic                  clk,
    input logic                  reset_n,
    output_port_arbiter_if.slave bus
);
    localparam int IW = $clog2(INPORTS);

    arb_state_e       state;
    logic [INPORTS-1:0] grant_q;
    logic [IW-1:0]    grant_id_q;
    logic             pkt_en_q;
    logic [IW-1:0]    ptr_q;

    logic [INPORTS-1:0] req_eff;
    logic [INPORTS-1:0] pick_gnt;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;

    // No U-turn: our own input never competes for this output.
    always_comb begin
        req_eff           = bus.req_i;
        req_eff[LOCATION] = 1'b0;
    end

    rr_picker #(.W(INPORTS), .IW(IW)) u_picker (
        .req (req_eff),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    wire own_tail = bus.tail_i[grant_id_q];

`ifdef OUTPORT_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] hold_cnt;
    logic          timeout_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            pkt_en_q   <= 1'b0;
            ptr_q      <= IW'(INPORTS - 1);
`ifdef OUTPORT_ARB_TIMEOUT_EN
            hold_cnt   <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
`ifdef OUTPORT_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (pick_any && !bus.busy_dw_i) begin
                        grant_q    <= pick_gnt;
                        grant_id_q <= pick_idx;
                        pkt_en_q   <= 1'b1;
                        ptr_q      <= pick_idx;
`ifdef OUTPORT_ARB_TIMEOUT_EN
                        hold_cnt   <= '0;
`endif
                        state      <= GRANT;
                    end
                end
                GRANT: begin
                    // Packet lock: req_i and busy_dw_i are ignored here.
                    if (own_tail) begin
                        grant_q  <= '0;
                        pkt_en_q <= 1'b0;
                        state    <= RELEASE;
                    end
`ifdef OUTPORT_ARB_TIMEOUT_EN
                    else if (hold_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        // ptr_q already names the victim, so it drops to
                        // lowest priority for the next round.
                        grant_q   <= '0;
                        pkt_en_q  <= 1'b0;
                        timeout_q <= 1'b1;
                        state     <= RELEASE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
`endif
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant_o         = grant_q;
    assign bus.grant_id_o      = grant_id_q;
    assign bus.packet_enable_o = pkt_en_q;
`ifdef OUTPORT_ARB_TIMEOUT_EN
    assign bus.timeout_o       = timeout_q;
`else
    assign bus.timeout_o       = 1'b0;
`endif

endmodule

// File: tb/tb_output_port_arbiter.sv
// Self-checking bench for output_port_arbiter (INPORTS=4, LOCATION=0,
// TIMEOUT_CYCLES=8). Expected grant indices go into a scoreboard queue when
// requests are driven and are popped when a grant appears.
module tb_output_port_arbiter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    output_port_arbiter_if #(.INPORTS(4)) bus ();

    output_port_arbiter #(
        .INPORTS(4), .LOCATION(0), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int exp_q[$];

    task automatic do_reset();
        bus.req_i     = '0;
        bus.tail_i    = '0;
        bus.busy_dw_i = 1'b0;
        reset_n       = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Bounded wait for a nonzero grant; n = edges waited, or -1 if expired.
    task automatic wait_grant(input int max, output int n);
        n = -1;
        for (int k = 1; k <= max; k++) begin
            @(posedge clk); #1;
            if (bus.grant_o != '0) begin
                n = k;
                return;
            end
        end
    endtask

    task automatic release_port(input logic [3:0] t);
        @(negedge clk);
        bus.tail_i = t;
        @(posedge clk); #1;
        vectors++;
        if (bus.grant_o !== 4'b0 || bus.packet_enable_o !== 1'b0) begin
            miscompares++;
            $display("FAIL release: grant_o=%b pe=%b, required 0000/0", bus.grant_o, bus.packet_enable_o);
        end
        @(negedge clk);
        bus.tail_i = '0;
    endtask

    task automatic test_reset();
        bus.req_i = '0; bus.tail_i = '0; bus.busy_dw_i = 1'b0;
        reset_n = 1'b0;
        #2;
        vectors++;
        if (bus.grant_o !== 4'b0 || bus.grant_id_o !== 2'd0 ||
            bus.packet_enable_o !== 1'b0 || bus.timeout_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: grant=%b id=%0d pe=%b to=%b, required all 0",
                     bus.grant_o, bus.grant_id_o, bus.packet_enable_o, bus.timeout_o);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_single_grant();
        int n, e;
        bit bad;
        exp_q.push_back(1);
        @(negedge clk);
        bus.req_i = 4'b0010;
        wait_grant(3, n);
        e = exp_q.pop_front();
        vectors++;
        if (n != 1 || bus.grant_o !== 4'(1 << e) || bus.grant_id_o !== 2'(e) ||
            bus.packet_enable_o !== 1'b1) begin
            miscompares++;
            $display("FAIL single_grant: lat=%0d grant=%b id=%0d pe=%b, required lat=1 id=%0d pe=1",
                     n, bus.grant_o, bus.grant_id_o, bus.packet_enable_o, e);
        end
        @(negedge clk);
        bus.req_i = '0;
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.grant_o !== 4'b0010 || bus.packet_enable_o !== 1'b1) bad = 1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL grant_hold: grant=%b pe=%b, required 0010/1", bus.grant_o, bus.packet_enable_o);
        end
        release_port(4'b0010);
    endtask

    task automatic test_location_mask();
        bit bad = 0;
        @(negedge clk);
        bus.req_i = 4'b0001;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus.grant_o !== 4'b0 || bus.packet_enable_o !== 1'b0) bad = 1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL location_mask: grant=%b, required 0000", bus.grant_o);
        end
        @(negedge clk);
        bus.req_i = '0;
    endtask

    task automatic test_round_robin();
        int n, e;
        do_reset();
        exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(1);
        @(negedge clk);
        bus.req_i = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            wait_grant(4, n);
            e = exp_q.pop_front();
            vectors++;
            if (bus.grant_id_o !== 2'(e) || bus.grant_o !== 4'(1 << e) || n < 0) begin
                miscompares++;
                $display("FAIL rr_order[%0d]: id=%0d grant=%b, required id=%0d", i, bus.grant_id_o, bus.grant_o, e);
            end
            if (i > 0) begin
                vectors++;
                if (n != 2) begin
                    miscompares++;
                    $display("FAIL rr_turnaround[%0d]: %0d cycles, required 2", i, n);
                end
            end
            repeat (2) @(posedge clk);
            release_port(bus.grant_o);
        end
        bus.req_i = '0;
    endtask

    task automatic test_tail_filter_busy();
        int n, e;
        bit bad = 0;
        do_reset();
        @(negedge clk);
        bus.busy_dw_i = 1'b1;
        bus.req_i     = 4'b0100;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.grant_o !== 4'b0) bad = 1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL busy_block: grant=%b, required 0000", bus.grant_o);
        end
        exp_q.push_back(2);
        @(negedge clk);
        bus.busy_dw_i = 1'b0;
        wait_grant(3, n);
        e = exp_q.pop_front();
        vectors++;
        if (n != 1 || bus.grant_id_o !== 2'(e) || bus.grant_o !== 4'b0100) begin
            miscompares++;
            $display("FAIL busy_release_grant: lat=%0d id=%0d grant=%b, required lat=1 id=%0d", n, bus.grant_id_o, bus.grant_o, e);
        end
        @(negedge clk);
        bus.tail_i = 4'b0010;
        @(posedge clk); #1;
        vectors++;
        if (bus.grant_o !== 4'b0100 || bus.packet_enable_o !== 1'b1) begin
            miscompares++;
            $display("FAIL tail_noise: grant=%b pe=%b, required 0100/1", bus.grant_o, bus.packet_enable_o);
        end
        @(negedge clk);
        bus.tail_i    = '0;
        bus.busy_dw_i = 1'b1;
        bad = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.grant_o !== 4'b0100) bad = 1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL busy_in_grant: grant=%b, required 0100", bus.grant_o);
        end
        bus.busy_dw_i = 1'b0;
        release_port(4'b0100);
        bus.req_i = '0;
    endtask

    task automatic test_timeout();
        int n, e;
        bit bad = 0;
        do_reset();
        exp_q.push_back(1); exp_q.push_back(2);
        @(negedge clk);
        bus.req_i = 4'b0110;
        wait_grant(3, n);
        e = exp_q.pop_front();
        vectors++;
        if (bus.grant_id_o !== 2'(e) || n != 1) begin
            miscompares++;
            $display("FAIL to_first_grant: id=%0d lat=%0d, required id=%0d lat=1", bus.grant_id_o, n, e);
        end
`ifdef OUTPORT_ARB_TIMEOUT_EN
        repeat (7) begin
            @(posedge clk); #1;
            if (bus.grant_o !== 4'b0010 || bus.timeout_o !== 1'b0) bad = 1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL to_hold: grant=%b to=%b, required 0010/0", bus.grant_o, bus.timeout_o);
        end
        @(posedge clk); #1;
        vectors++;
        if (bus.grant_o !== 4'b0 || bus.timeout_o !== 1'b1) begin
            miscompares++;
            $display("FAIL to_fire: grant=%b to=%b, required 0000/1", bus.grant_o, bus.timeout_o);
        end
        @(posedge clk); #1;
        vectors++;
        if (bus.timeout_o !== 1'b0) begin
            miscompares++;
            $display("FAIL to_pulse_width: to=%b, required 0", bus.timeout_o);
        end
`else
        repeat (100) begin
            @(posedge clk); #1;
            if (bus.grant_o !== 4'b0010 || bus.timeout_o !== 1'b0) bad = 1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL no_timeout_hold: grant=%b to=%b, required 0010/0", bus.grant_o, bus.timeout_o);
        end
        release_port(4'b0010);
`endif
        wait_grant(4, n);
        e = exp_q.pop_front();
        vectors++;
        if (bus.grant_id_o !== 2'(e) || n < 0) begin
            miscompares++;
            $display("FAIL to_next_grant: id=%0d, required %0d", bus.grant_id_o, e);
        end
        release_port(4'b0100);
        bus.req_i = '0;
    endtask

    task automatic test_reset_mid_packet();
        int n, e;
        do_reset();
        exp_q.push_back(1);
        @(negedge clk);
        bus.req_i = 4'b0010;
        wait_grant(3, n);
        e = exp_q.pop_front();
        vectors++;
        if (bus.grant_id_o !== 2'(e)) begin
            miscompares++;
            $display("FAIL mid_first: id=%0d, required %0d", bus.grant_id_o, e);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        vectors++;
        if (bus.grant_o !== 4'b0 || bus.packet_enable_o !== 1'b0 || bus.grant_id_o !== 2'd0) begin
            miscompares++;
            $display("FAIL async_reset: grant=%b pe=%b id=%0d, required 0", bus.grant_o, bus.packet_enable_o, bus.grant_id_o);
        end
        bus.req_i = 4'b1110;
        exp_q.push_back(1);
        @(negedge clk);
        reset_n = 1'b1;
        wait_grant(3, n);
        e = exp_q.pop_front();
        vectors++;
        if (n != 1 || bus.grant_id_o !== 2'(e)) begin
            miscompares++;
            $display("FAIL post_reset_priority: lat=%0d id=%0d, required lat=1 id=%0d", n, bus.grant_id_o, e);
        end
        bus.req_i = '0;
        release_port(bus.grant_o);
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_location_mask();
        test_round_robin();
        test_tail_filter_busy();
        test_timeout();
        test_reset_mid_packet();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
